// File: rtl/pipe_ctrl_regs.sv
// Control-side stage registers of the 5-stage pipeline.
// Carries the ID instruction and its decoded control bundle through EXE, MEM
// and WB. Returns valid flags and hazard/forwarding feedback to the controller.
// Every stage follows the same rule: a reset clears it to a bubble, otherwise
// an enable loads it from upstream, otherwise it holds its contents.
module pipe_ctrl_regs #(
   parameter logic [2:0] PC_NEXT      = 3'd0,
   parameter logic [1:0] WB_ADDR_RD   = 2'd0,
   parameter logic [1:0] WB_ADDR_RT   = 2'd1,
   parameter logic [1:0] WB_ADDR_LINK = 2'd2,
   parameter logic [4:0] GPR_RA       = 5'd31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst_if,
   output logic [31:0] inst_id,
   input  logic [2:0]  pc_src,
   input  logic [1:0]  wb_addr_src,
   input  logic        wb_wen,
   input  logic        mem_ren,
   input  logic        mem_wen,
   input  logic        if_rst,
   input  logic        id_rst,
   input  logic        exe_rst,
   input  logic        mem_rst,
   input  logic        wb_rst,
   input  logic        if_en,
   input  logic        id_en,
   input  logic        exe_en,
   input  logic        mem_en,
   input  logic        wb_en,
   output logic        if_valid,
   output logic        id_valid,
   output logic        exe_valid,
   output logic        mem_valid,
   output logic        wb_valid,
   output logic        is_branch_exe,
   output logic        is_branch_mem,
   output logic [4:0]  regw_addr_exe,
   output logic [4:0]  regw_addr_mem,
   output logic [4:0]  regw_addr_wb,
   output logic        wb_wen_exe,
   output logic        wb_wen_mem,
   output logic        wb_wen_wb,
   output logic        mem_ren_mem,
   output logic        mem_wen_mem,
   output logic [4:0]  addr_rs_exe,
   output logic [4:0]  addr_rt_exe
);

   // IF stage
   logic        if_valid_reg;
   // ID stage
   logic        id_valid_reg;
   logic [31:0] inst_id_reg;
   // EXE stage
   logic        exe_valid_reg;
   logic [4:0]  regw_addr_exe_reg;
   logic        is_branch_exe_reg;
   logic        wb_wen_exe_reg;
   logic        mem_ren_exe_reg;
   logic        mem_wen_exe_reg;
   logic [4:0]  addr_rs_exe_reg;
   logic [4:0]  addr_rt_exe_reg;
   // MEM stage
   logic        mem_valid_reg;
   logic [4:0]  regw_addr_mem_reg;
   logic        is_branch_mem_reg;
   logic        wb_wen_mem_reg;
   logic        mem_ren_mem_reg;
   logic        mem_wen_mem_reg;
   // WB stage
   logic        wb_valid_reg;
   logic [4:0]  regw_addr_wb_reg;
   logic        wb_wen_wb_reg;

   // Destination register selected by the ID decode; unused code 3 maps to $0
   logic [4:0]  regw_addr_next;

   // Decode the write-address source of the instruction sitting in ID
   always_comb begin
      regw_addr_next = 5'd0;
      if (wb_addr_src == WB_ADDR_RD)
         regw_addr_next = inst_id_reg[15:11];
      else if (wb_addr_src == WB_ADDR_RT)
         regw_addr_next = inst_id_reg[20:16];
      else if (wb_addr_src == WB_ADDR_LINK)
         regw_addr_next = GPR_RA;
   end

   // IF stage: only tracks whether fetch is producing a real instruction
   always_ff @(posedge clk) begin
      if (rst || if_rst)
         if_valid_reg <= 1'b0;
      else if (if_en)
         if_valid_reg <= 1'b1;
   end

   // ID stage: latches the fetched instruction
   always_ff @(posedge clk) begin
      if (rst || id_rst) begin
         id_valid_reg <= 1'b0;
         inst_id_reg  <= 32'h0;
      end else if (id_en) begin
         id_valid_reg <= if_valid_reg;
         inst_id_reg  <= inst_if;
      end
   end

   // EXE stage: captures the controller's decode of the ID instruction
   always_ff @(posedge clk) begin
      if (rst || exe_rst) begin
         exe_valid_reg     <= 1'b0;
         regw_addr_exe_reg <= 5'd0;
         is_branch_exe_reg <= 1'b0;
         wb_wen_exe_reg    <= 1'b0;
         mem_ren_exe_reg   <= 1'b0;
         mem_wen_exe_reg   <= 1'b0;
         addr_rs_exe_reg   <= 5'd0;
         addr_rt_exe_reg   <= 5'd0;
      end else if (exe_en) begin
         exe_valid_reg     <= id_valid_reg;
         regw_addr_exe_reg <= regw_addr_next;
         is_branch_exe_reg <= (pc_src != PC_NEXT);
         wb_wen_exe_reg    <= wb_wen;
         mem_ren_exe_reg   <= mem_ren;
         mem_wen_exe_reg   <= mem_wen;
         addr_rs_exe_reg   <= inst_id_reg[25:21];
         addr_rt_exe_reg   <= inst_id_reg[20:16];
      end
   end

   // MEM stage: forwards the EXE control bundle
   always_ff @(posedge clk) begin
      if (rst || mem_rst) begin
         mem_valid_reg     <= 1'b0;
         regw_addr_mem_reg <= 5'd0;
         is_branch_mem_reg <= 1'b0;
         wb_wen_mem_reg    <= 1'b0;
         mem_ren_mem_reg   <= 1'b0;
         mem_wen_mem_reg   <= 1'b0;
      end else if (mem_en) begin
         mem_valid_reg     <= exe_valid_reg;
         regw_addr_mem_reg <= regw_addr_exe_reg;
         is_branch_mem_reg <= is_branch_exe_reg;
         wb_wen_mem_reg    <= wb_wen_exe_reg;
         mem_ren_mem_reg   <= mem_ren_exe_reg;
         mem_wen_mem_reg   <= mem_wen_exe_reg;
      end
   end

   // WB stage: only the register write-back information is still needed
   always_ff @(posedge clk) begin
      if (rst || wb_rst) begin
         wb_valid_reg     <= 1'b0;
         regw_addr_wb_reg <= 5'd0;
         wb_wen_wb_reg    <= 1'b0;
      end else if (wb_en) begin
         wb_valid_reg     <= mem_valid_reg;
         regw_addr_wb_reg <= regw_addr_mem_reg;
         wb_wen_wb_reg    <= wb_wen_mem_reg;
      end
   end

   // Flags are qualified by stage valid so bubbles never look like hazards;
   // addresses are passed through raw and the controller filters them.
   assign if_valid      = if_valid_reg;
   assign id_valid      = id_valid_reg;
   assign exe_valid     = exe_valid_reg;
   assign mem_valid     = mem_valid_reg;
   assign wb_valid      = wb_valid_reg;
   assign inst_id       = inst_id_reg;
   assign is_branch_exe = exe_valid_reg & is_branch_exe_reg;
   assign is_branch_mem = mem_valid_reg & is_branch_mem_reg;
   assign wb_wen_exe    = exe_valid_reg & wb_wen_exe_reg;
   assign wb_wen_mem    = mem_valid_reg & wb_wen_mem_reg;
   assign wb_wen_wb     = wb_valid_reg & wb_wen_wb_reg;
   assign mem_ren_mem   = mem_valid_reg & mem_ren_mem_reg;
   assign mem_wen_mem   = mem_valid_reg & mem_wen_mem_reg;
   assign regw_addr_exe = regw_addr_exe_reg;
   assign regw_addr_mem = regw_addr_mem_reg;
   assign regw_addr_wb  = regw_addr_wb_reg;
   assign addr_rs_exe   = addr_rs_exe_reg;
   assign addr_rt_exe   = addr_rt_exe_reg;

endmodule
